// File: rtl/cs_address_sequencer.sv
// cs_address_sequencer
//   Next-address logic for the microprogrammed datapath. Holds the micro-PC
//   and the PSR condition flags {N,Z,V,C}. Each cycle it picks the next
//   control-store address: increment, conditional/unconditional jump, or
//   instruction decode.
//
// Ports
//   CS_ADDRESS_SEQUENCER_CLOCK_50          system clock, rising edge
//   CS_ADDRESS_SEQUENCER_ResetInHigh_In    synchronous active-high reset
//   CS_ADDRESS_SEQUENCER_Hold_In           freeze micro-PC and flags
//   CS_ADDRESS_SEQUENCER_Condition_InBus   COND field of current microinstruction
//   CS_ADDRESS_SEQUENCER_JumpAddress_InBus JUMP ADDR field of current microinstruction
//   CS_ADDRESS_SEQUENCER_IR_InBus          instruction register
//   CS_ADDRESS_SEQUENCER_ALUFlags_InBus    {N,Z,V,C} from the ALU this cycle
//   CS_ADDRESS_SEQUENCER_SetCC_In          latch ALU flags on this edge
//   CS_ADDRESS_SEQUENCER_CSAddress_OutBus  registered micro-PC
//   CS_ADDRESS_SEQUENCER_Flags_OutBus      registered PSR flags {N,Z,V,C}

module cs_address_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_IR          = 32,
  parameter int DATAWIDTH_FLAGS       = 4
) (
  input  logic                             CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic                             CS_ADDRESS_SEQUENCER_ResetInHigh_In,
  input  logic                             CS_ADDRESS_SEQUENCER_Hold_In,
  input  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus,
  input  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
  input  logic [DATAWIDTH_IR-1:0]          CS_ADDRESS_SEQUENCER_IR_InBus,
  input  logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_ALUFlags_InBus,
  input  logic                             CS_ADDRESS_SEQUENCER_SetCC_In,
  output logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus,
  output logic [DATAWIDTH_FLAGS-1:0]       CS_ADDRESS_SEQUENCER_Flags_OutBus
);

  localparam logic [DATAWIDTH_CONDITION-1:0] COND_INC    = 3'b000;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_N      = 3'b001;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_Z      = 3'b010;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_V      = 3'b011;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_C      = 3'b100;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_IR13   = 3'b101;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_JUMP   = 3'b110;
  localparam logic [DATAWIDTH_CONDITION-1:0] COND_DECODE = 3'b111;

  localparam logic [DATAWIDTH_JUMPADDRESS-1:0] ONE = 1;

  logic [DATAWIDTH_JUMPADDRESS-1:0] upc_q, upc_d;
  logic [DATAWIDTH_FLAGS-1:0]       flags_q, flags_d;
  logic [DATAWIDTH_JUMPADDRESS-1:0] inc_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] decode_addr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] next_addr;
  logic                             flag_n, flag_z, flag_v, flag_c;

  // Branches test the registered flags, so a same-cycle SetCC only affects
  // branches from the following microinstruction onward.
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_c = flags_q[0];

  // Wraps modulo 2^width with no side effects.
  assign inc_addr = upc_q + ONE;

  // Decode entry point: {1, op, op3, 00}, four microwords per opcode.
  assign decode_addr = {1'b1,
                        CS_ADDRESS_SEQUENCER_IR_InBus[31:30],
                        CS_ADDRESS_SEQUENCER_IR_InBus[24:19],
                        2'b00};

  always_comb begin
    next_addr = inc_addr;
    case (CS_ADDRESS_SEQUENCER_Condition_InBus)
      COND_INC:    next_addr = inc_addr;
      COND_N:      if (flag_n) next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      COND_Z:      if (flag_z) next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      COND_V:      if (flag_v) next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      COND_C:      if (flag_c) next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      COND_IR13:   if (CS_ADDRESS_SEQUENCER_IR_InBus[13])
                     next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      COND_JUMP:   next_addr = CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
      COND_DECODE: next_addr = decode_addr;
      default:     next_addr = inc_addr;
    endcase
  end

  always_comb begin
    upc_d   = upc_q;
    flags_d = flags_q;
    if (!CS_ADDRESS_SEQUENCER_Hold_In) begin
      upc_d = next_addr;
      if (CS_ADDRESS_SEQUENCER_SetCC_In)
        flags_d = CS_ADDRESS_SEQUENCER_ALUFlags_InBus;
    end
  end

  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50) begin
    if (CS_ADDRESS_SEQUENCER_ResetInHigh_In) begin
      upc_q   <= '0;
      flags_q <= '0;
    end else begin
      upc_q   <= upc_d;
      flags_q <= flags_d;
    end
  end

  assign CS_ADDRESS_SEQUENCER_CSAddress_OutBus = upc_q;
  assign CS_ADDRESS_SEQUENCER_Flags_OutBus     = flags_q;

endmodule

// File: tb/tb_cs_address_sequencer.sv
module tb_cs_address_sequencer;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [2:0]  cond;
  logic [10:0] jmp;
  logic [31:0] ir;
  logic [3:0]  alu;
  logic        setcc;
  logic [10:0] cs_addr;
  logic [3:0]  flags;

  typedef struct {
    logic [10:0] addr;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  cs_address_sequencer dut (
    .CS_ADDRESS_SEQUENCER_CLOCK_50          (clk),
    .CS_ADDRESS_SEQUENCER_ResetInHigh_In    (rst),
    .CS_ADDRESS_SEQUENCER_Hold_In           (hold),
    .CS_ADDRESS_SEQUENCER_Condition_InBus   (cond),
    .CS_ADDRESS_SEQUENCER_JumpAddress_InBus (jmp),
    .CS_ADDRESS_SEQUENCER_IR_InBus          (ir),
    .CS_ADDRESS_SEQUENCER_ALUFlags_InBus    (alu),
    .CS_ADDRESS_SEQUENCER_SetCC_In          (setcc),
    .CS_ADDRESS_SEQUENCER_CSAddress_OutBus  (cs_addr),
    .CS_ADDRESS_SEQUENCER_Flags_OutBus      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one microinstruction cycle at the falling edge and queue what the
  // outputs must read after the next rising edge.
  task automatic step(input logic r, input logic h, input logic [2:0] c,
                      input logic [10:0] j, input logic [31:0] i,
                      input logic sc, input logic [3:0] a,
                      input logic [10:0] ea, input logic [3:0] ef,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; hold = h; cond = c; jmp = j; ir = i; setcc = sc; alu = a;
    e.addr = ea; e.flg = ef; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: one registered output set per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (cs_addr === e.addr) n_pass++;
        else $display("FAIL %s addr: got %0d expected %0d", e.name, cs_addr, e.addr);
        n_total++;
        if (flags === e.flg) n_pass++;
        else $display("FAIL %s flags: got %b expected %b", e.name, flags, e.flg);
      end
    end
  end

  initial begin
    rst = 1'b1; hold = 1'b0; cond = 3'b000; jmp = '0; ir = '0; setcc = 1'b0; alu = '0;

    // reset and plain increment
    step(1, 0, 3'b000, 11'd0, 32'h0, 0, 4'h0, 11'd0, 4'b0000, "reset");
    step(0, 0, 3'b000, 11'd0, 32'h0, 0, 4'h0, 11'd1, 4'b0000, "inc1");
    step(0, 0, 3'b000, 11'd0, 32'h0, 0, 4'h0, 11'd2, 4'b0000, "inc2");
    step(0, 0, 3'b000, 11'd0, 32'h0, 0, 4'h0, 11'd3, 4'b0000, "inc3");
    step(0, 0, 3'b000, 11'd0, 32'h0, 0, 4'h0, 11'd4, 4'b0000, "inc4");
    step(0, 0, 3'b000, 11'd0, 32'h0, 0, 4'h0, 11'd5, 4'b0000, "inc5");

    // unconditional jump to top, then wrap
    step(0, 0, 3'b110, 11'h7FF, 32'h0, 0, 4'h0, 11'd2047, 4'b0000, "jmp_top");
    step(0, 0, 3'b000, 11'd0,   32'h0, 0, 4'h0, 11'd0,    4'b0000, "wrap");
    step(0, 0, 3'b000, 11'd0,   32'h0, 0, 4'h0, 11'd1,    4'b0000, "after_wrap");

    // same-cycle SetCC uses old Z; next cycle sees new Z
    step(0, 0, 3'b010, 11'd100, 32'h0, 1, 4'b0100, 11'd2,   4'b0100, "z_old");
    step(0, 0, 3'b010, 11'd100, 32'h0, 0, 4'b0000, 11'd100, 4'b0100, "z_new");
    step(0, 0, 3'b001, 11'd200, 32'h0, 0, 4'b0000, 11'd101, 4'b0100, "n_clear");

    // N=1 Z=0 V=1 C=1
    step(0, 0, 3'b000, 11'd0,   32'h0, 1, 4'b1011, 11'd102, 4'b1011, "setcc_1011");
    step(0, 0, 3'b001, 11'd200, 32'h0, 0, 4'b0000, 11'd200, 4'b1011, "n_set");
    step(0, 0, 3'b010, 11'd300, 32'h0, 0, 4'b0000, 11'd201, 4'b1011, "z_clear");
    step(0, 0, 3'b011, 11'd400, 32'h0, 0, 4'b0000, 11'd400, 4'b1011, "v_set");
    step(0, 0, 3'b100, 11'd17,  32'h0, 0, 4'b0000, 11'd17,  4'b1011, "c_set");
    step(0, 0, 3'b100, 11'd50,  32'h0, 1, 4'b0000, 11'd50,  4'b0000, "c_old");
    step(0, 0, 3'b100, 11'd60,  32'h0, 0, 4'b0000, 11'd51,  4'b0000, "c_new_clear");

    // decode and IR[13] branch
    step(0, 0, 3'b111, 11'd0,  32'h8200_6000, 0, 4'h0, 11'd1536, 4'b0000, "decode_1536");
    step(0, 0, 3'b101, 11'd40, 32'h8200_6000, 0, 4'h0, 11'd40,   4'b0000, "ir13_set");
    step(0, 0, 3'b101, 11'd90, 32'h0000_4000, 0, 4'h0, 11'd41,   4'b0000, "ir13_clear");
    step(0, 0, 3'b111, 11'd0,  32'h41F8_0000, 0, 4'h0, 11'd1532, 4'b0000, "decode_1532");

    // hold freezes PC and flags, SetCC ignored
    step(0, 1, 3'b110, 11'd500, 32'h0, 1, 4'b1111, 11'd1532, 4'b0000, "hold1");
    step(0, 1, 3'b110, 11'd500, 32'h0, 1, 4'b1111, 11'd1532, 4'b0000, "hold2");
    step(0, 1, 3'b110, 11'd500, 32'h0, 1, 4'b1111, 11'd1532, 4'b0000, "hold3");
    step(0, 0, 3'b110, 11'd500, 32'h0, 1, 4'b1111, 11'd500,  4'b1111, "release");

    // reset discards a pending jump
    step(1, 0, 3'b110, 11'd700, 32'h0, 0, 4'h0, 11'd0, 4'b0000, "reset_mid");
    step(0, 0, 3'b000, 11'd0,   32'h0, 0, 4'h0, 11'd1, 4'b0000, "post_reset");

    @(negedge clk);
    rst = 1'b0; hold = 1'b1; cond = 3'b000; setcc = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cs_address_sequencer.md
Name: cs_address_sequencer

Overview:
- Control-branch / next-address logic for the microprogrammed datapath: the consumer end of the microinstruction Condition and JumpAddress fields, and the producer of the control-store address.
- Holds the micro-PC and the PSR condition flags (N,Z,V,C).
- Each cycle it selects the next CS address: increment, conditional or unconditional jump, or instruction decode. It drives the control-store address bus that the microcode store reads.

Parameters:
DATAWIDTH_JUMPADDRESS, 11, CS address / micro-PC width
DATAWIDTH_CONDITION, 3, microinstruction condition field width
DATAWIDTH_IR, 32, instruction register width
DATAWIDTH_FLAGS, 4, PSR flag width, ordered {N,Z,V,C}

Ports:
CS_ADDRESS_SEQUENCER_CLOCK_50  in  1  system clock, rising edge
CS_ADDRESS_SEQUENCER_ResetInHigh_In  in  1  synchronous active-high reset
CS_ADDRESS_SEQUENCER_Hold_In  in  1  freezes micro-PC and flags (memory wait)
CS_ADDRESS_SEQUENCER_Condition_InBus  in  3  COND field of current microinstruction
CS_ADDRESS_SEQUENCER_JumpAddress_InBus  in  11  JUMP ADDR field of current microinstruction
CS_ADDRESS_SEQUENCER_IR_InBus  in  32  instruction register contents
CS_ADDRESS_SEQUENCER_ALUFlags_InBus  in  4  {N,Z,V,C} from ALU, current cycle
CS_ADDRESS_SEQUENCER_SetCC_In  in  1  current ALU op is cc-setting; latch flags
CS_ADDRESS_SEQUENCER_CSAddress_OutBus  out  11  registered micro-PC, sent to microcode store
CS_ADDRESS_SEQUENCER_Flags_OutBus  out  4  registered PSR flags {N,Z,V,C}

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state changes on the rising edge of CLOCK_50.
- Reset (highest priority, sampled on the edge): micro-PC <= 0, flags <= 4'b0000. Both outputs read 0 in the cycle after the reset edge. Reset mid-sequence discards any pending jump or decode.
- The CSAddress output is the micro-PC register itself. The microcode store is combinational from it, so its Condition and JumpAddress fields are valid within the same cycle.
- Next address is combinational from the current COND, the *registered* flags, and IR:
  - 000: micro-PC + 1
  - 001: JumpAddress if N, else +1
  - 010: JumpAddress if Z, else +1
  - 011: JumpAddress if V, else +1
  - 100: JumpAddress if C, else +1
  - 101: JumpAddress if IR[13], else +1
  - 110: JumpAddress unconditionally
  - 111: DECODE = {1'b1, IR[31:30], IR[24:19], 2'b00}
- Increment is modulo 2^11: 2047 + 1 -> 0, with no flag or error.
- Branch latency: the selected address appears on CSAddress exactly 1 clock after the microinstruction that selects it.
- Flag update: when SetCC=1 and Hold=0, flags <= ALUFlags_InBus on the edge. When SetCC=0, flags are held.
- Same-cycle SetCC and a conditional branch: the branch evaluates the OLD registered flags. New flags are visible to branches starting the next cycle.
- Hold=1 (and Reset=0): micro-PC and flags keep their values and SetCC is ignored. The condition inputs may change freely; no side effects.
- Priority: Reset > Hold > normal update.
- No X propagation: all 8 COND codes are defined, so no default-to-X arm is needed.

Test Plan:
- Reset then COND=000 for 5 clocks -> CSAddress sequence 0,1,2,3,4,5; Flags = 0000.
- Micro-PC driven to 2047 via jump (COND=110, Jump=11'h7FF), then COND=000 -> CSAddress 2047 then 0 (wrap).
- SetCC=1, ALUFlags=4'b0100 with COND=010, Jump=100 in the same cycle -> falls through to PC+1 (old Z=0). Next cycle COND=010, Jump=100 -> CSAddress=100; Flags=0100.
- IR=32'h8200_6000 (op=10, op3=000000, bit13=1), COND=111 -> CSAddress = 11'b1_10_000000_00 = 1536. Then COND=101, Jump=40 -> CSAddress=40.
- Hold=1 for 3 clocks with COND=110, Jump=500 and SetCC=1, ALUFlags=1111 -> CSAddress and Flags unchanged. Release Hold -> CSAddress=500, Flags=1111.
- Reset asserted while COND=110, Jump=700 -> CSAddress=0 and Flags=0000 the next cycle. Deassert with COND=000 -> 1.
